cache_ctrl_assoc: RTL
=====================

# cache_ctrl_assoc

Parametrised set-associative, write-back, write-allocate cache controller built on the team's cache data model: valid/dirty/tag per line, 32-bit CPU word requests, whole-line memory transfers. It sits between the CPU request/result interface and the memory request/response interface. It generalises the direct-mapped 128-set, 128-bit-line organisation to configurable sets, ways, line width and word width, and adds per-set round-robin replacement.

## Interface
- ADDR_W, 32, byte address width
- WORD_W, 32, CPU data width; power of 2, ≥8
- LINE_W, 128, cache line width; power-of-2 multiple of WORD_W
- SETS, 128, number of sets; power of 2, ≥2
- WAYS, 2, associativity; power of 2, 1..8
- Derived: OFF_W=log2(LINE_W/8), IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W, WSEL_W=log2(LINE_W/WORD_W)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- cpu_req_addr  in  ADDR_W  request byte address
- cpu_req_data  in  WORD_W  write data
- cpu_req_rw  in  1  0=read, 1=write
- cpu_req_valid  in  1  request valid
- cpu_res_data  out  WORD_W  read data
- cpu_res_ready  out  1  one-cycle completion pulse
- mem_req_addr  out  ADDR_W  line-aligned address
- mem_req_data  out  LINE_W  write-back line
- mem_req_rw  out  1  0=line fill, 1=write-back
- mem_req_valid  out  1  memory request valid
- mem_data_data  in  LINE_W  fill data
- mem_data_ready  in  1  one-cycle pulse: request complete / fill data valid

## Operation
- Address split: tag=addr[ADDR_W-1:IDX_W+OFF_W], index=addr[IDX_W+OFF_W-1:OFF_W], word select=addr[OFF_W-1:OFF_W-WSEL_W]; remaining low byte bits ignored. Writes are full-word.
- Storage per set/way: valid, dirty, tag, LINE_W data. Per set: log2(WAYS)-bit round-robin pointer (absent when WAYS=1).
- States: IDLE, COMPARE, WRITE_BACK, ALLOCATE.
- IDLE: on cpu_req_valid=1, register addr/data/rw → COMPARE. cpu_req_valid ignored in all other states; CPU need not hold the request after it is sampled.
- COMPARE: hit = valid & tag match in any way (at most one can match).
  - Read hit: cpu_res_data ← selected word; pulse cpu_res_ready; → IDLE.
  - Write hit: update word, set dirty; pulse cpu_res_ready (cpu_res_data unchanged); → IDLE.
  - Miss: victim = lowest-numbered invalid way; if none, way at the set's pointer, and pointer increments modulo WAYS. Victim dirty → WRITE_BACK, else → ALLOCATE.
- WRITE_BACK: mem_req_valid=1, rw=1, addr={victim tag, index, 0}, data=victim line; on mem_data_ready → ALLOCATE.
- ALLOCATE: mem_req_valid=1, rw=0, addr={req tag, index, 0}; on mem_data_ready write mem_data_data into victim way, valid=1, dirty=0, tag=req tag → COMPARE (guaranteed hit, completes as above).
- mem_req_* stay stable while mem_req_valid=1; mem_req_valid drops the cycle after mem_data_ready is sampled unless the next state issues a new request.

## Timing
- All outputs registered. Reset values: cpu_res_data=0, cpu_res_ready=0, mem_req_valid=0, mem_req_rw=0, mem_req_addr=0, mem_req_data=0; state IDLE; all valid/dirty=0; all pointers=0. Tag/data arrays not reset.
- Hit: valid sampled at edge E0; cpu_res_ready high for exactly the cycle after E1; next request sampled no earlier than E2.
- Clean miss: mem_req_valid rises after E1; with ready sampled at edge Em, cpu_res_ready high for the cycle after Em+2.
- Dirty miss adds one write-back transaction before the fill; mem_req_valid may stay high continuously across write-back→fill, with rw/addr changing on that edge.
- mem_data_ready outside WRITE_BACK/ALLOCATE is ignored.
- Reset asserted mid-operation: immediate return to reset values, request abandoned, no cpu_res_ready, dirty data discarded.

## Test plan
- Defaults, cold read 0x0000_1004: fill request addr 0x0000_1000 rw=0; return line with word1=0x1111_1111 → cpu_res_data=0x1111_1111, single ready pulse, no write-back.
- Write hit 0xDEAD_BEEF to 0x0000_1008 after fill: ready the cycle after E1, no memory activity; read 0x0000_1008 returns 0xDEAD_BEEF.
- WAYS=2 conflict: after 0x1000 (dirty) and 0x2000 fill both ways of set 0, read 0x3000 → write-back addr 0x1000 rw=1 with 0xDEAD_BEEF in word 2, then fill 0x3000; next 0x4000 evicts the 0x2000 way without write-back.
- Memory stall: mem_data_ready delayed 10 cycles → mem_req_valid/addr/data/rw constant throughout, no cpu_res_ready until fill.
- Reset asserted during WRITE_BACK: mem_req_valid low without waiting for a clock edge; after release, read 0x1000 misses with a clean fill.
- WAYS=1, SETS=4: alternating reads 0x0000 and 0x0040 each miss and refill; a write before eviction forces a write-back.

Source files
------------

// File: rtl/cache_ctrl_assoc.sv
// Set-associative, write-back, write-allocate cache controller.
// Holds valid/dirty/tag/line per way and a round-robin victim pointer per set.
// Serves 32-bit CPU word requests and moves whole lines to and from memory.
module cache_ctrl_assoc #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_W = 128,
  parameter int SETS   = 128,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [WORD_W-1:0] cpu_req_data,
  input  logic              cpu_req_rw,
  input  logic              cpu_req_valid,
  output logic [WORD_W-1:0] cpu_res_data,
  output logic              cpu_res_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_data,
  output logic              mem_req_rw,
  output logic              mem_req_valid,
  input  logic [LINE_W-1:0] mem_data_data,
  input  logic              mem_data_ready
);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WSEL_W = $clog2(LINE_W / WORD_W);
  localparam int WSEL_B = (WSEL_W > 0) ? WSEL_W : 1;
  localparam int BYTE_W = OFF_W - WSEL_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;

  state_t             state;
  logic               fill_done;
  logic [WAY_W-1:0]   victim_q;

  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   req_idx;
  logic [WSEL_B-1:0]  req_wsel;
  logic [WORD_W-1:0]  req_data;
  logic               req_rw;

  logic [WAYS-1:0]    valid_q [SETS];
  logic [WAYS-1:0]    dirty_q [SETS];
  logic [WAY_W-1:0]   ptr_q   [SETS];
  logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
  logic [LINE_W-1:0]  data_q  [SETS][WAYS];

  logic [WSEL_B-1:0]  cpu_wsel;
  logic               hit, any_inv;
  logic [WAY_W-1:0]   hit_way, inv_way, victim_sel;
  logic [LINE_W-1:0]  hit_line;
  logic [WORD_W-1:0]  hit_word;
  logic               fill_we, wr_hit_we, ptr_adv;

  if (WSEL_W > 0) begin : g_wsel
    assign cpu_wsel = cpu_req_addr[OFF_W-1:BYTE_W];
  end else begin : g_no_wsel
    assign cpu_wsel = '0;
  end

  // Byte-within-word bits play no part in a full-word access.
  if (BYTE_W > 0) begin : g_byte
    logic unused_byte_bits;
    assign unused_byte_bits = ^cpu_req_addr[BYTE_W-1:0];
  end

  // Tag lookup across the ways of the requested set, plus the victim choice.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    any_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req_idx][w]) begin
        any_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    victim_sel = any_inv ? inv_way : ptr_q[req_idx];
    hit_line   = data_q[req_idx][hit_way];
    hit_word   = hit_line[req_wsel*WORD_W +: WORD_W];
    fill_we    = (state == ALLOCATE) && !fill_done && mem_data_ready;
    wr_hit_we  = (state == COMPARE) && hit && req_rw;
    ptr_adv    = (state == COMPARE) && !hit && !any_inv;
  end

  // Capture the CPU request when it is accepted; it need not be held afterwards.
  always_ff @(posedge clk) begin
    if (state == IDLE && cpu_req_valid) begin
      req_tag  <= cpu_req_addr[ADDR_W-1:IDX_W+OFF_W];
      req_idx  <= cpu_req_addr[IDX_W+OFF_W-1:OFF_W];
      req_wsel <= cpu_wsel;
      req_data <= cpu_req_data;
      req_rw   <= cpu_req_rw;
    end
  end

  // Tag and line storage: written by a fill or by a write hit, never reset.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[req_idx][victim_q] <= mem_data_data;
      tag_q[req_idx][victim_q]  <= req_tag;
    end else if (wr_hit_we) begin
      data_q[req_idx][hit_way][req_wsel*WORD_W +: WORD_W] <= req_data;
    end
  end

  // Line state bits and replacement pointers; reset invalidates everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      if (fill_we) begin
        valid_q[req_idx][victim_q] <= 1'b1;
        dirty_q[req_idx][victim_q] <= 1'b0;
      end
      if (wr_hit_we) dirty_q[req_idx][hit_way] <= 1'b1;
      if (ptr_adv) ptr_q[req_idx] <= (WAYS > 1) ? ptr_q[req_idx] + 1'b1 : '0;
    end
  end

  // Controller FSM with registered CPU and memory outputs.
  // A completed fill spends one extra cycle in ALLOCATE so the new line is
  // in the arrays before COMPARE looks at it again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      fill_done     <= 1'b0;
      victim_q      <= '0;
      cpu_res_data  <= '0;
      cpu_res_ready <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
      mem_req_rw    <= 1'b0;
      mem_req_valid <= 1'b0;
    end else begin
      cpu_res_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req_valid) state <= COMPARE;
        end
        COMPARE: begin
          if (hit) begin
            if (!req_rw) cpu_res_data <= hit_word;
            cpu_res_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            victim_q      <= victim_sel;
            mem_req_valid <= 1'b1;
            if (valid_q[req_idx][victim_sel] && dirty_q[req_idx][victim_sel]) begin
              mem_req_rw   <= 1'b1;
              mem_req_addr <= {tag_q[req_idx][victim_sel], req_idx, {OFF_W{1'b0}}};
              mem_req_data <= data_q[req_idx][victim_sel];
              state        <= WRITE_BACK;
            end else begin
              mem_req_rw   <= 1'b0;
              mem_req_addr <= {req_tag, req_idx, {OFF_W{1'b0}}};
              state        <= ALLOCATE;
            end
          end
        end
        WRITE_BACK: begin
          if (mem_data_ready) begin
            mem_req_rw   <= 1'b0;
            mem_req_addr <= {req_tag, req_idx, {OFF_W{1'b0}}};
            state        <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (fill_done) begin
            fill_done <= 1'b0;
            state     <= COMPARE;
          end else if (mem_data_ready) begin
            mem_req_valid <= 1'b0;
            fill_done     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
